// File: rtl/reloj_pkg.sv
// reloj_pkg: shared state encoding and defaults for the reloj stopwatch control slice.
package reloj_pkg;

  // Width of the control state encoding shown on the debug/LED port.
  localparam int ST_W = 2;

  // Default number of stable synchronised samples before a button level is accepted.
  localparam int DEB_CYCLES_DEFAULT = 16;

  // Control states; the encoding is visible on the state output.
  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

endpackage

// File: rtl/reloj_debounce.sv
// reloj_debounce: two-flop synchroniser, stability counter and press-edge detector
// for one raw push-button. A press is a single-cycle pulse on the debounced rising edge.
module reloj_debounce
  import reloj_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic press
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [DEB_W-1:0] r_count;

  // Bring the asynchronous button into the clock domain through two flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= din;
      r_sync2 <= r_sync1;
    end
  end

  // Count consecutive disagreeing samples; flip the level once the run is long enough.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_level <= 1'b0;
      r_count <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_count <= '0;
      end else if (r_count == DEB_W'(DEB_CYCLES)) begin
        r_level <= ~r_level;
        r_count <= '0;
        r_press <= ~r_level;
      end else begin
        r_count <= r_count + DEB_W'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/reloj_ctrl.sv
// reloj_ctrl: button conditioning and run/clear/lap sequencing for the reloj timekeeper.
// Optional lap view is built only when RELOJ_CTRL_LAP_EN is defined; otherwise the
// reset/lap button is ignored while running and hold stays low.
module reloj_ctrl
  import reloj_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btn_ss,
  input  logic            btn_rst,
  output logic            run,
  output logic            clr,
  output logic            hold,
  output logic [ST_W-1:0] state
);

  logic   w_ssPress;
  logic   w_rsPress;
  logic   w_unusedSsLevel;
  logic   w_unusedRsLevel;
  state_t w_nextState;
  logic   w_clrEvent;

  state_t r_state;
  logic   r_run;
  logic   r_clr;
  logic   r_hold;

  reloj_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debSs (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_ss),
    .level (w_unusedSsLevel),
    .press (w_ssPress)
  );

  reloj_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debRst (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_rst),
    .level (w_unusedRsLevel),
    .press (w_rsPress)
  );

  // Next-state rule; a simultaneous press of both buttons is a hard clear to IDLE.
  function automatic state_t nextState(input state_t cur, input logic ss, input logic rs);
    state_t nxt;
    nxt = cur;
    if (ss && rs) begin
      nxt = ST_IDLE;
    end else if (ss) begin
      case (cur)
        ST_IDLE:  nxt = ST_RUN;
        ST_RUN:   nxt = ST_PAUSE;
        ST_PAUSE: nxt = ST_RUN;
        ST_LAP:   nxt = ST_PAUSE;
        default:  nxt = ST_IDLE;
      endcase
    end else if (rs) begin
      case (cur)
        ST_IDLE:  nxt = ST_IDLE;
`ifdef RELOJ_CTRL_LAP_EN
        ST_RUN:   nxt = ST_LAP;
`else
        ST_RUN:   nxt = ST_RUN;
`endif
        ST_PAUSE: nxt = ST_IDLE;
        ST_LAP:   nxt = ST_RUN;
        default:  nxt = ST_IDLE;
      endcase
    end
    return nxt;
  endfunction

  assign w_nextState = nextState(r_state, w_ssPress, w_rsPress);
  assign w_clrEvent  = (w_ssPress && w_rsPress) ||
                       (w_rsPress && ((r_state == ST_IDLE) || (r_state == ST_PAUSE)));

  // State register with outputs decoded from the next state so they change with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_run   <= 1'b0;
      r_clr   <= 1'b0;
      r_hold  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_run   <= (w_nextState == ST_RUN) || (w_nextState == ST_LAP);
      r_clr   <= w_clrEvent;
`ifdef RELOJ_CTRL_LAP_EN
      r_hold  <= (w_nextState == ST_LAP);
`else
      r_hold  <= 1'b0;
`endif
    end
  end

  assign run   = r_run;
  assign clr   = r_clr;
  assign hold  = r_hold;
  assign state = r_state;

endmodule

// File: tb/tb_reloj_ctrl.sv
// tb_reloj_ctrl: directed vector bench for reloj_ctrl with DEB_CYCLES=4.
module tb_reloj_ctrl;

  localparam int DEB = 4;

`ifdef RELOJ_CTRL_LAP_EN
  localparam logic [1:0] LAP_ST   = 2'b11;
  localparam logic       LAP_HOLD = 1'b1;
`else
  localparam logic [1:0] LAP_ST   = 2'b01;
  localparam logic       LAP_HOLD = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       btnSs;
  logic       btnRst;
  logic       run;
  logic       clr;
  logic       hold;
  logic [1:0] state;

  typedef struct {
    logic       ss;
    logic       rs;
    int         n;
    logic [1:0] expState;
    logic       expRun;
    logic       expClr;
    logic       expHold;
  } vec_t;

  vec_t vecs[$];
  int   checkCount = 0;
  int   errorCount = 0;

  reloj_ctrl #(.DEB_CYCLES(DEB)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_ss  (btnSs),
    .btn_rst (btnRst),
    .run     (run),
    .clr     (clr),
    .hold    (hold),
    .state   (state)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, landing 1 unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Hold the buttons at the given levels for n cycles.
  task automatic applyStimulus(input logic ss, input logic rs, input int n);
    btnSs  = ss;
    btnRst = rs;
    tick(n);
  endtask

  // One comparison of an observed value against its expected value.
  task automatic compare(input string name, input logic [1:0] got, input logic [1:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Compare all four DUT outputs against the expected values.
  task automatic checkOutput(input string name, input logic [1:0] es, input logic er,
                             input logic ec, input logic eh);
    compare({name, " state"}, state, es);
    compare({name, " run"}, {1'b0, run}, {1'b0, er});
    compare({name, " clr"}, {1'b0, clr}, {1'b0, ec});
    compare({name, " hold"}, {1'b0, hold}, {1'b0, eh});
  endtask

  function automatic void addVec(input logic ss, input logic rs, input int n,
                                 input logic [1:0] es, input logic er,
                                 input logic ec, input logic eh);
    vec_t v;
    v.ss       = ss;
    v.rs       = rs;
    v.n        = n;
    v.expState = es;
    v.expRun   = er;
    v.expClr   = ec;
    v.expHold  = eh;
    vecs.push_back(v);
  endfunction

  initial begin
    // Press released from reset: state changes 7 edges after first sample, then held.
    addVec(1, 0, 7,   2'b00, 0, 0, 0);
    addVec(1, 0, 1,   2'b01, 1, 0, 0);
    addVec(1, 0, 10,  2'b01, 1, 0, 0);
    addVec(0, 0, 10,  2'b01, 1, 0, 0);
    // RUN -> PAUSE, then PAUSE -> IDLE with one clear cycle while held.
    addVec(1, 0, 7,   2'b01, 1, 0, 0);
    addVec(1, 0, 1,   2'b10, 0, 0, 0);
    addVec(0, 0, 10,  2'b10, 0, 0, 0);
    addVec(0, 1, 7,   2'b10, 0, 0, 0);
    addVec(0, 1, 1,   2'b00, 0, 1, 0);
    addVec(0, 1, 1,   2'b00, 0, 0, 0);
    addVec(0, 1, 10,  2'b00, 0, 0, 0);
    addVec(0, 0, 10,  2'b00, 0, 0, 0);
    // Glitches of 3 and 4 raw cycles are rejected; 5 cycles is the shortest press.
    addVec(1, 0, 3,   2'b00, 0, 0, 0);
    addVec(0, 0, 15,  2'b00, 0, 0, 0);
    addVec(1, 0, 4,   2'b00, 0, 0, 0);
    addVec(0, 0, 15,  2'b00, 0, 0, 0);
    addVec(1, 0, 5,   2'b00, 0, 0, 0);
    addVec(0, 0, 2,   2'b00, 0, 0, 0);
    addVec(0, 0, 1,   2'b01, 1, 0, 0);
    addVec(0, 0, 15,  2'b01, 1, 0, 0);
    // Lap view entered and left with the reset/lap button.
    addVec(0, 1, 8,   LAP_ST, 1, 0, LAP_HOLD);
    addVec(0, 0, 10,  LAP_ST, 1, 0, LAP_HOLD);
    addVec(0, 1, 8,   2'b01, 1, 0, 0);
    addVec(0, 0, 10,  2'b01, 1, 0, 0);
    // Lap view left with start/stop goes to PAUSE; then back to RUN.
    addVec(0, 1, 8,   LAP_ST, 1, 0, LAP_HOLD);
    addVec(0, 0, 10,  LAP_ST, 1, 0, LAP_HOLD);
    addVec(1, 0, 8,   2'b10, 0, 0, 0);
    addVec(0, 0, 10,  2'b10, 0, 0, 0);
    addVec(1, 0, 8,   2'b01, 1, 0, 0);
    addVec(0, 0, 10,  2'b01, 1, 0, 0);
    // Both buttons together: hard clear, single pulse even held for 200 cycles.
    addVec(1, 1, 7,   2'b01, 1, 0, 0);
    addVec(1, 1, 1,   2'b00, 0, 1, 0);
    addVec(1, 1, 1,   2'b00, 0, 0, 0);
    addVec(1, 1, 200, 2'b00, 0, 0, 0);
    addVec(0, 0, 10,  2'b00, 0, 0, 0);
    addVec(1, 1, 8,   2'b00, 0, 1, 0);
    addVec(1, 1, 1,   2'b00, 0, 0, 0);
    addVec(0, 0, 10,  2'b00, 0, 0, 0);
    // Reset/lap press while IDLE clears again.
    addVec(0, 1, 8,   2'b00, 0, 1, 0);
    addVec(0, 1, 1,   2'b00, 0, 0, 0);
    addVec(0, 0, 10,  2'b00, 0, 0, 0);

    rst    = 1'b0;
    btnSs  = 1'b0;
    btnRst = 1'b0;
    tick(3);
    checkOutput("reset", 2'b00, 0, 0, 0);

    rst   = 1'b1;
    btnSs = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ss, vecs[i].rs, vecs[i].n);
      checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expRun,
                  vecs[i].expClr, vecs[i].expHold);
    end

    // Reset in the middle of a debounce count aborts it without a later press.
    applyStimulus(1, 0, 8);
    checkOutput("abort run", 2'b01, 1, 0, 0);
    applyStimulus(0, 0, 10);
    applyStimulus(1, 0, 4);
    rst = 1'b0;
    #1;
    checkOutput("abort async", 2'b00, 0, 0, 0);
    btnSs = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(20);
    checkOutput("abort quiet", 2'b00, 0, 0, 0);

    // A button held through reset release gives one press after the normal latency.
    btnSs = 1'b1;
    rst   = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(7);
    checkOutput("held early", 2'b00, 0, 0, 0);
    tick(1);
    checkOutput("held press", 2'b01, 1, 0, 0);
    applyStimulus(1, 0, 20);
    checkOutput("held single", 2'b01, 1, 0, 0);
    applyStimulus(0, 0, 10);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
